// File: rtl/riscfw_pkg.sv
// Shared RV32I core definitions: opcode fields, sequencer states, trap causes,
// writeback select codes and the next-PC rule used in EXEC.
package riscfw_pkg;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } seq_state_e;

    typedef enum logic [1:0] {
        CAUSE_ILLEGAL    = 2'd0,
        CAUSE_SYSTEM     = 2'd1,
        CAUSE_MISALIGNED = 2'd2,
        CAUSE_BUS        = 2'd3
    } trap_cause_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    // JALR clears bit 0 of the ALU target; everything else is PC-relative.
    function automatic logic [31:0] calc_next_pc(
        input logic [4:0]  opcode,
        input logic [31:0] pc,
        input logic [31:0] imm,
        input logic [31:0] alu_result,
        input logic        br_taken
    );
        logic [31:0] result;
        case (opcode)
            OP_JAL:    result = pc + imm;
            OP_JALR:   result = alu_result & 32'hFFFF_FFFE;
            OP_BRANCH: result = br_taken ? (pc + imm) : (pc + 32'd4);
            default:   result = pc + 32'd4;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-cycle counter for an outstanding memory request; flags the last
// permitted wait cycle so the sequencer can raise a bus trap.
module bus_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_enabled
            assign expired = (cnt == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle RV32I sequencer: fetches into the IR, then steps decode, execute,
// memory and writeback. Owns the PC, memory handshakes, rf write, retire and trap.
module core_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    input  logic [4:0]  dec_opcode,
    input  logic [31:0] dec_imm,
    input  logic        dec_rd_valid,
    input  logic        dec_error,
    input  logic        br_taken,
    input  logic [31:0] alu_result,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [31:0] pc,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    import riscfw_pkg::*;

    seq_state_e  state, state_d;
    trap_cause_e cause_q, cause_d;
    wb_sel_e     wb_sel_d;
    logic [31:0] next_pc_q, next_pc_calc;
    logic        enter_trap;
    logic        waiting, bus_ready, expired;

    assign next_pc_calc = calc_next_pc(dec_opcode, pc, dec_imm, alu_result, br_taken);

    // One timer serves both FETCH and MEM; it is held clear in every other state,
    // which gives the clear-on-entry behaviour without tracking the previous state.
    assign waiting   = (state == ST_FETCH) || (state == ST_MEM);
    assign bus_ready = (state == ST_FETCH) ? imem_ready : dmem_ready;

    bus_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!waiting || bus_ready),
        .en     (waiting && !bus_ready),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            instr     <= '0;
            next_pc_q <= '0;
            cause_q   <= CAUSE_ILLEGAL;
        end else begin
            state <= state_d;
            if (state == ST_FETCH && imem_ready) begin
                instr <= imem_rdata;
            end
            if (state == ST_EXEC) begin
                next_pc_q <= next_pc_calc;
            end
            if (state == ST_WB) begin
                pc <= next_pc_q;
            end
            if (enter_trap) begin
                cause_q <= cause_d;
            end
        end
    end

    always_comb begin
        state_d    = state;
        cause_d    = CAUSE_ILLEGAL;
        enter_trap = 1'b0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        rf_we      = 1'b0;
        wb_sel_d   = WB_ALU;
        retire     = 1'b0;
        trap       = 1'b0;
        case (state)
            ST_FETCH: begin
                // Reset parks the FSM in FETCH; keep the request off until release.
                imem_req = rst_n;
                if (imem_ready) begin
                    state_d = ST_DECODE;
                end else if (expired) begin
                    state_d    = ST_TRAP;
                    cause_d    = CAUSE_BUS;
                    enter_trap = 1'b1;
                end
            end
            ST_DECODE: begin
                if (dec_error) begin
                    state_d    = ST_TRAP;
                    cause_d    = CAUSE_ILLEGAL;
                    enter_trap = 1'b1;
                end else if (dec_opcode == OP_SYSTEM) begin
                    state_d    = ST_TRAP;
                    cause_d    = CAUSE_SYSTEM;
                    enter_trap = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (next_pc_calc[1:0] != 2'b00) begin
                    state_d    = ST_TRAP;
                    cause_d    = CAUSE_MISALIGNED;
                    enter_trap = 1'b1;
                end else if (dec_opcode == OP_LOAD || dec_opcode == OP_STORE) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (dec_opcode == OP_STORE);
                if (dmem_ready) begin
                    state_d = ST_WB;
                end else if (expired) begin
                    state_d    = ST_TRAP;
                    cause_d    = CAUSE_BUS;
                    enter_trap = 1'b1;
                end
            end
            ST_WB: begin
                rf_we  = dec_rd_valid;
                retire = 1'b1;
                if (dec_opcode == OP_LOAD) begin
                    wb_sel_d = WB_MEM;
                end else if (dec_opcode == OP_JAL || dec_opcode == OP_JALR) begin
                    wb_sel_d = WB_PC4;
                end
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    assign imem_addr  = pc;
    assign wb_sel     = wb_sel_d;
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Randomized bench for core_seq_ctrl: a per-instruction outcome model (cycle
// count, next PC, trap cause, writeback controls) checked against the DUT.
module tb_core_seq_ctrl;

    import riscfw_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_1000;
    localparam int          TMO    = 4;
    localparam logic [4:0]  OP_IMM = 5'b00100;
    localparam logic [4:0]  OP_REG = 5'b01100;
    localparam logic [4:0]  OP_LUI = 5'b01101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
    logic [31:0] imem_addr, imem_rdata, instr, dec_imm, alu_result, pc;
    logic [4:0]  dec_opcode;
    logic        dec_rd_valid, dec_error, br_taken, rf_we, retire, trap;
    logic [1:0]  wb_sel, trap_cause;

    core_seq_ctrl #(
        .RESET_PC(RST_PC),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .dec_opcode  (dec_opcode),
        .dec_imm     (dec_imm),
        .dec_rd_valid(dec_rd_valid),
        .dec_error   (dec_error),
        .br_taken    (br_taken),
        .alu_result  (alu_result),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ready  (dmem_ready),
        .rf_we       (rf_we),
        .wb_sel      (wb_sel),
        .pc          (pc),
        .retire      (retire),
        .trap        (trap),
        .trap_cause  (trap_cause)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        check("rst_pc", pc, RST_PC);
        check("rst_instr", instr, 32'd0);
        check("rst_imem_req", imem_req, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_strobes", {rf_we, retire, trap}, 0);
        check("rst_cause", trap_cause, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        model_pc = RST_PC;
        #1;
    endtask

    // Runs one instruction from its first FETCH cycle; fd/md are the number of
    // not-ready cycles the instruction/data memories insert before ready.
    task automatic run_instr(input logic [4:0] op, input logic [31:0] imm, input logic [31:0] alu,
                             input logic br, input logic rdv, input logic err,
                             input int fd, input int md);
        logic [31:0] word, rnd, tgt;
        logic        is_mem, saw_ret, saw_trap, hold_bad;
        int          exp_trap, exp_cyc, cyc, end_cyc, ireq, dreq, addr_bad, we_bad;
        logic [1:0]  exp_wb;

        rnd    = $urandom();
        word   = {rnd[31:7], op, 2'b11};
        is_mem = (op == OP_LOAD) || (op == OP_STORE);
        case (op)
            OP_JAL:    tgt = model_pc + imm;
            OP_JALR:   tgt = alu & 32'hFFFF_FFFE;
            OP_BRANCH: tgt = br ? model_pc + imm : model_pc + 32'd4;
            default:   tgt = model_pc + 32'd4;
        endcase
        exp_wb = (op == OP_LOAD) ? 2'd1 : ((op == OP_JAL || op == OP_JALR) ? 2'd2 : 2'd0);

        exp_trap = -1;
        if (fd >= TMO) begin
            exp_trap = 3; exp_cyc = TMO + 1;
        end else if (err) begin
            exp_trap = 0; exp_cyc = fd + 3;
        end else if (op == OP_SYSTEM) begin
            exp_trap = 1; exp_cyc = fd + 3;
        end else if (tgt[1:0] != 2'b00) begin
            exp_trap = 2; exp_cyc = fd + 4;
        end else if (is_mem && md >= TMO) begin
            exp_trap = 3; exp_cyc = fd + 4 + TMO;
        end else begin
            exp_cyc = fd + 4 + (is_mem ? md + 1 : 0);
        end

        dec_opcode   = op;
        dec_imm      = imm;
        alu_result   = alu;
        br_taken     = br;
        dec_rd_valid = rdv;
        dec_error    = err;
        imem_rdata   = word;

        cyc = 0; end_cyc = 0; ireq = 0; dreq = 0; addr_bad = 0; we_bad = 0;
        saw_ret = 1'b0; saw_trap = 1'b0;
        while (!saw_ret && !saw_trap && cyc < 60) begin
            cyc++;
            if (retire) begin
                saw_ret = 1'b1;
                end_cyc = cyc;
                check("wb_rf_we", rf_we, rdv);
                check("wb_sel", wb_sel, exp_wb);
                check("wb_instr", instr, word);
            end
            if (trap) begin
                saw_trap = 1'b1;
                end_cyc  = cyc;
            end
            if (imem_req) begin
                if (imem_addr !== model_pc) addr_bad++;
                imem_ready = (ireq == fd);
                ireq++;
            end else begin
                imem_ready = 1'b0;
            end
            if (dmem_req) begin
                if (dmem_we !== (op == OP_STORE)) we_bad++;
                dmem_ready = (dreq == md);
                dreq++;
            end else begin
                dmem_ready = 1'b0;
            end
            @(negedge clk);
            #1;
        end

        check("outcome_trap", saw_trap, exp_trap >= 0);
        check("end_cycle", end_cyc, exp_cyc);
        check("imem_addr", addr_bad, 0);
        if (is_mem) check("dmem_we", we_bad, 0);

        if (exp_trap < 0 && saw_ret) begin
            check("next_pc", pc, tgt);
            check("fetch_cycles", ireq, fd + 1);
            if (is_mem) check("mem_cycles", dreq, md + 1);
            model_pc = tgt;
        end
        if (exp_trap >= 0 && saw_trap) begin
            check("trap_cause", trap_cause, exp_trap);
            check("trap_pc", pc, model_pc);
            if (fd < TMO) check("trap_instr", instr, word);
            hold_bad = 1'b0;
            for (int i = 0; i < 5; i++) begin
                if (imem_req || dmem_req || rf_we || retire || !trap || pc !== model_pc)
                    hold_bad = 1'b1;
                @(negedge clk);
                #1;
            end
            check("trap_hold", hold_bad, 0);
        end
        if (saw_trap || !saw_ret) do_reset();
    endtask

    task automatic reset_mid_mem();
        logic [31:0] word;
        word         = {25'h0, OP_LOAD, 2'b11};
        dec_opcode   = OP_LOAD;
        dec_error    = 1'b0;
        dec_rd_valid = 1'b1;
        alu_result   = 32'h40;
        imem_rdata   = word;
        dmem_ready   = 1'b0;
        for (int i = 0; i < 10 && !dmem_req; i++) begin
            imem_ready = imem_req;
            @(negedge clk);
            #1;
        end
        imem_ready = 1'b0;
        check("midmem_req_seen", dmem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midmem_req_drop", dmem_req, 0);
        check("midmem_pc", pc, RST_PC);
        @(negedge clk);
        rst_n    = 1'b1;
        model_pc = RST_PC;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [4:0]  op;
        logic [31:0] r1, r2, imm;
        int          fd, md;

        rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; imem_rdata = '0;
        dec_opcode = '0; dec_imm = '0; dec_rd_valid = 1'b0; dec_error = 1'b0;
        br_taken = 1'b0; alu_result = '0; model_pc = RST_PC;
        do_reset();

        run_instr(OP_IMM, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0, 0, 0);
        run_instr(OP_JAL, 32'h10 - model_pc, 32'd0, 1'b0, 1'b1, 1'b0, 0, 0);
        run_instr(OP_BRANCH, 32'd8, 32'd0, 1'b1, 1'b0, 1'b0, 0, 0);
        run_instr(OP_JAL, 32'h10 - model_pc, 32'd0, 1'b0, 1'b0, 1'b0, 1, 0);
        run_instr(OP_BRANCH, 32'd8, 32'd0, 1'b0, 1'b0, 1'b0, 0, 0);
        run_instr(OP_LOAD, 32'd0, 32'h80, 1'b0, 1'b1, 1'b0, 0, 3);
        run_instr(OP_STORE, 32'd0, 32'h84, 1'b0, 1'b0, 1'b0, 3, 0);
        reset_mid_mem();
        run_instr(OP_JAL, 32'hFFFF_FFFC - model_pc, 32'd0, 1'b0, 1'b1, 1'b0, 0, 0);
        run_instr(OP_REG, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 0, 0);
        run_instr(OP_JALR, 32'd0, 32'h103, 1'b0, 1'b1, 1'b0, 0, 0);
        run_instr(OP_IMM, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 0, 0);
        run_instr(OP_SYSTEM, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 0, 0);
        run_instr(OP_IMM, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, TMO, 0);
        run_instr(OP_LOAD, 32'd0, 32'h20, 1'b0, 1'b1, 1'b0, 0, TMO);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0:       op = OP_LOAD;
                1:       op = OP_STORE;
                2:       op = OP_BRANCH;
                3:       op = OP_JAL;
                4:       op = OP_JALR;
                5:       op = OP_LUI;
                6:       op = OP_REG;
                7:       op = ($urandom_range(0, 3) == 0) ? OP_SYSTEM : OP_IMM;
                default: op = OP_IMM;
            endcase
            r1  = $urandom();
            r2  = $urandom();
            imm = {r1[31:2], ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00};
            fd  = ($urandom_range(0, 24) == 0) ? TMO + $urandom_range(0, 1) : $urandom_range(0, 3);
            md  = ($urandom_range(0, 12) == 0) ? TMO : $urandom_range(0, 3);
            run_instr(op, imm, r2, r1[0], r1[1], ($urandom_range(0, 19) == 0), fd, md);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
